// File: rtl/detector_jogada.sv
// detector_jogada: synchronizes, debounces and validates the four raw
// push-button lines. Each accepted single-key play produces one registered
// one-hot code on jogada plus a one-cycle jogada_feita pulse. Multi-key
// presses are rejected with a jogada_invalida pulse. After every play a full
// release is required before the next one is armed.
module detector_jogada #(
    parameter int DEBOUNCE = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic [3:0] chaves,
    output logic [3:0] jogada,
    output logic       jogada_feita,
    output logic       jogada_invalida,
    output logic [3:0] db_estado
);

    // The counter must hold DEBOUNCE-1. It keeps at least one bit so that
    // DEBOUNCE=1 still elaborates.
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    // The encodings double as the hex-display codes.
    typedef enum logic [3:0] {
        OCIOSO    = 4'h1,
        FILTRANDO = 4'h2,
        ACEITA    = 4'h3,
        INVALIDA  = 4'h4,
        SOLTAR    = 4'h5
    } estado_t;

    estado_t       estado, estado_nxt;
    logic [3:0]    sinc_a, sinc;
    logic [3:0]    amostra, amostra_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    jogada_nxt;
    logic          um_quente;

    // Two-flop synchronizer; the FSM only ever looks at sinc.
    always_ff @(posedge clock) begin
        if (reset) begin
            sinc_a <= 4'b0000;
            sinc   <= 4'b0000;
        end else begin
            sinc_a <= chaves;
            sinc   <= sinc_a;
        end
    end

    // Captured pattern is accepted only if exactly one key is pressed.
    assign um_quente = (amostra != 4'b0000) && ((amostra & (amostra - 4'd1)) == 4'b0000);

    // State, counter, captured pattern and output play register.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado  <= SOLTAR;
            cnt     <= '0;
            amostra <= 4'b0000;
            jogada  <= 4'b0000;
        end else begin
            estado  <= estado_nxt;
            cnt     <= cnt_nxt;
            amostra <= amostra_nxt;
            jogada  <= jogada_nxt;
        end
    end

    // Next-state logic. jogada is loaded on the edge that enters ACEITA.
    always_comb begin
        estado_nxt  = estado;
        cnt_nxt     = cnt;
        amostra_nxt = amostra;
        jogada_nxt  = jogada;
        unique case (estado)
            SOLTAR: begin
                // Wait for DEBOUNCE consecutive all-released cycles.
                if (sinc == 4'b0000) begin
                    if (cnt == CNT_MAX) begin
                        estado_nxt = OCIOSO;
                        cnt_nxt    = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end else begin
                    cnt_nxt = '0;
                end
            end
            OCIOSO: begin
                if (habilita && (sinc != 4'b0000)) begin
                    amostra_nxt = sinc;
                    cnt_nxt     = '0;
                    estado_nxt  = FILTRANDO;
                end
            end
            FILTRANDO: begin
                if (!habilita) begin
                    estado_nxt = SOLTAR;
                    cnt_nxt    = '0;
                end else if (sinc == 4'b0000) begin
                    // Short glitch: discard it and wait for a new press.
                    estado_nxt = OCIOSO;
                end else if (sinc != amostra) begin
                    // Pattern changed while filtering: restart on the new one.
                    amostra_nxt = sinc;
                    cnt_nxt     = '0;
                end else if (cnt == CNT_MAX) begin
                    cnt_nxt = '0;
                    if (um_quente) begin
                        estado_nxt = ACEITA;
                        jogada_nxt = amostra;
                    end else begin
                        estado_nxt = INVALIDA;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ACEITA: begin
                estado_nxt = SOLTAR;
                cnt_nxt    = '0;
            end
            INVALIDA: begin
                estado_nxt = SOLTAR;
                cnt_nxt    = '0;
            end
            default: begin
                estado_nxt = SOLTAR;
                cnt_nxt    = '0;
            end
        endcase
    end

    // Moore outputs decoded from the state register only.
    assign jogada_feita    = (estado == ACEITA);
    assign jogada_invalida = (estado == INVALIDA);
    assign db_estado       = estado;

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada with DEBOUNCE=4. Inputs change 1 ns
// after a rising edge, and outputs are sampled at that same point.
module tb_detector_jogada;

    logic       clock = 1'b0;
    logic       reset;
    logic       habilita;
    logic [3:0] chaves;
    logic [3:0] jogada;
    logic       jogada_feita;
    logic       jogada_invalida;
    logic [3:0] db_estado;

    int total = 0;
    int bad   = 0;
    int viol  = 0;
    int nf, ni;
    logic prev_f = 1'b0, prev_i = 1'b0;

    detector_jogada #(.DEBOUNCE(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .habilita        (habilita),
        .chaves          (chaves),
        .jogada          (jogada),
        .jogada_feita    (jogada_feita),
        .jogada_invalida (jogada_invalida),
        .db_estado       (db_estado)
    );

    always #5 clock = ~clock;

    // Pulse exclusivity / single-cycle monitor.
    always @(negedge clock) begin
        if (!reset) begin
            if (jogada_feita && jogada_invalida) viol++;
            if (jogada_feita && prev_f) viol++;
            if (jogada_invalida && prev_i) viol++;
        end
        prev_f = jogada_feita;
        prev_i = jogada_invalida;
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles, counting the pulses seen.
    task automatic run_count(input int n, output int f, output int iv);
        f = 0;
        iv = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (jogada_feita) f++;
            if (jogada_invalida) iv++;
        end
    endtask

    initial begin
        reset = 1'b1; habilita = 1'b0; chaves = 4'b0000;
        step(2);
        chk("rst_estado", 32'(db_estado), 32'h5);
        chk("rst_jogada", 32'(jogada), 32'h0);
        chk("rst_feita", 32'(jogada_feita), 32'h0);
        chk("rst_invalida", 32'(jogada_invalida), 32'h0);

        // 1: release hold-off, then a single press with exact latency.
        reset = 1'b0; habilita = 1'b1;
        step(3);
        chk("t1_soltar", 32'(db_estado), 32'h5);
        step(1);
        chk("t1_ocioso", 32'(db_estado), 32'h1);
        chaves = 4'b0100;
        step(2);
        chk("t1_e2", 32'(db_estado), 32'h1);
        step(1);
        chk("t1_e3", 32'(db_estado), 32'h2);
        step(3);
        chk("t1_e6", 32'(db_estado), 32'h2);
        chk("t1_e6_feita", 32'(jogada_feita), 32'h0);
        step(1);
        chk("t1_e7", 32'(db_estado), 32'h3);
        chk("t1_e7_feita", 32'(jogada_feita), 32'h1);
        chk("t1_e7_jogada", 32'(jogada), 32'h4);
        step(1);
        chk("t1_e8", 32'(db_estado), 32'h5);
        chk("t1_e8_feita", 32'(jogada_feita), 32'h0);
        run_count(5, nf, ni);
        chk("t1_hold_pulses", 32'(nf), 32'd0);
        chk("t1_jogada_hold", 32'(jogada), 32'h4);

        // 2: bounce rejection, then a stable hold.
        chaves = 4'b0000;
        step(8);
        chk("t2_ocioso", 32'(db_estado), 32'h1);
        nf = 0; ni = 0;
        for (int k = 0; k < 5; k++) begin
            int a, b;
            chaves = 4'b0010;
            run_count(2, a, b);
            nf += a; ni += b;
            chaves = 4'b0000;
            run_count(2, a, b);
            nf += a; ni += b;
        end
        chk("t2_bounce_feita", 32'(nf), 32'd0);
        chk("t2_bounce_inval", 32'(ni), 32'd0);
        chaves = 4'b0010;
        run_count(12, nf, ni);
        chk("t2_hold_feita", 32'(nf), 32'd1);
        chk("t2_hold_inval", 32'(ni), 32'd0);
        chk("t2_jogada", 32'(jogada), 32'h2);

        // 3: multi-key press is rejected.
        chaves = 4'b0000;
        step(8);
        chk("t3_ocioso", 32'(db_estado), 32'h1);
        chaves = 4'b0011;
        run_count(10, nf, ni);
        chk("t3_inval", 32'(ni), 32'd1);
        chk("t3_feita", 32'(nf), 32'd0);
        chk("t3_jogada", 32'(jogada), 32'h2);
        chk("t3_soltar", 32'(db_estado), 32'h5);
        run_count(10, nf, ni);
        chk("t3_held_inval", 32'(ni), 32'd0);

        // 4: held key does not re-trigger; short release does not re-arm.
        chaves = 4'b0000;
        step(8);
        chaves = 4'b1000;
        run_count(50, nf, ni);
        chk("t4_held_feita", 32'(nf), 32'd1);
        chk("t4_jogada8", 32'(jogada), 32'h8);
        chaves = 4'b0000;
        step(3);
        chaves = 4'b0001;
        run_count(15, nf, ni);
        chk("t4_short_rel", 32'(nf), 32'd0);
        chk("t4_short_state", 32'(db_estado), 32'h5);
        chaves = 4'b0000;
        step(4);
        chaves = 4'b0001;
        run_count(15, nf, ni);
        chk("t4_full_rel", 32'(nf), 32'd1);
        chk("t4_jogada1", 32'(jogada), 32'h1);

        // 5: habilita gating.
        chaves = 4'b0000;
        step(8);
        habilita = 1'b0;
        chaves = 4'b0100;
        run_count(10, nf, ni);
        chk("t5_gated_feita", 32'(nf), 32'd0);
        chk("t5_gated_state", 32'(db_estado), 32'h1);
        habilita = 1'b1;
        step(1);
        chk("t5_filt", 32'(db_estado), 32'h2);
        step(1);
        habilita = 1'b0;
        step(1);
        chk("t5_drop_filt", 32'(db_estado), 32'h5);
        run_count(10, nf, ni);
        chk("t5_drop_feita", 32'(nf), 32'd0);
        chaves = 4'b0000;
        habilita = 1'b1;
        step(8);
        chaves = 4'b0100;
        step(7);
        chk("t5_aceita", 32'(db_estado), 32'h3);
        chk("t5_aceita_feita", 32'(jogada_feita), 32'h1);
        habilita = 1'b0;
        step(1);
        chk("t5_after_aceita", 32'(db_estado), 32'h5);
        chk("t5_jogada", 32'(jogada), 32'h4);

        // 6: reset mid-operation.
        chaves = 4'b0000;
        habilita = 1'b1;
        step(8);
        chaves = 4'b0001;
        step(3);
        chk("t6_filt", 32'(db_estado), 32'h2);
        reset = 1'b1;
        step(1);
        chk("t6_rst_filt_state", 32'(db_estado), 32'h5);
        chk("t6_rst_filt_jogada", 32'(jogada), 32'h0);
        chk("t6_rst_filt_feita", 32'(jogada_feita), 32'h0);
        reset = 1'b0;
        chaves = 4'b0000;
        step(8);
        chk("t6_ocioso", 32'(db_estado), 32'h1);
        chaves = 4'b0010;
        step(7);
        chk("t6_aceita", 32'(db_estado), 32'h3);
        chk("t6_aceita_jogada", 32'(jogada), 32'h2);
        reset = 1'b1;
        step(1);
        chk("t6_rst_ac_state", 32'(db_estado), 32'h5);
        chk("t6_rst_ac_jogada", 32'(jogada), 32'h0);
        chk("t6_rst_ac_feita", 32'(jogada_feita), 32'h0);
        reset = 1'b0;
        chaves = 4'b0000;
        step(2);

        chk("pulse_exclusive", 32'(viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
